// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from several requesters into a single
// uart_transmitter. One byte is handed over per slot: the grant pulses
// tx_start together with the winner's req_ready, then the block waits for the
// transmitter to go busy and idle again before it arbitrates the next byte.
// A transmitter that never goes busy is detected with a bounded wait and
// reported through a sticky timeout flag.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BUSY_WAIT_MAX = 16,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active,
  output logic                 timeout_err,
  input  logic                 clear_err
);

  localparam int CW = $clog2(BUSY_WAIT_MAX + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  wait_cnt;

  logic [7:0]     req_byte [NUM_REQ];
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           timeout_fire;

  // Successor of a requester index, wrapping the last requester back to 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NUM_REQ - 1)) return '0;
    return id + IDW'(1);
  endfunction

  // Split the flat data bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_valid[IDW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  // Last allowed WAIT_BUSY cycle with the transmitter still idle: the counter
  // would reach BUSY_WAIT_MAX at this edge.
  assign timeout_fire = (state == S_WAIT_BUSY) && !tx_busy &&
                        (wait_cnt == CW'(BUSY_WAIT_MAX - 1));

  assign active = (state != S_IDLE);

  // Main FSM: grant in IDLE, then track the transmitter through busy and done.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      tx_start  <= 1'b0;
      req_ready <= '0;
      tx_data   <= 8'h00;
      grant_id  <= '0;
    end else begin
      // Accept and start strobes are single-cycle pulses by default.
      tx_start  <= 1'b0;
      req_ready <= '0;
      case (state)
        S_IDLE: begin
          if (win_found && !tx_busy) begin
            state     <= S_WAIT_BUSY;
            tx_data   <= req_byte[win_idx];
            grant_id  <= win_idx;
            tx_start  <= 1'b1;
            req_ready <= NUM_REQ'(1) << win_idx;
            wait_cnt  <= '0;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state    <= S_WAIT_DONE;
            wait_cnt <= '0;
          end else if (timeout_fire) begin
            state    <= S_IDLE;
            rr_ptr   <= next_id(grant_id);
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            state  <= S_IDLE;
            rr_ptr <= next_id(grant_id);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as clear_err wins.
  always_ff @(posedge clk) begin
    if (rst)               timeout_err <= 1'b0;
    else if (timeout_fire) timeout_err <= 1'b1;
    else if (clear_err)    timeout_err <= 1'b0;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of byte requesters (legal range 2..8).
REQ-002 The block SHALL have parameter BUSY_WAIT_MAX, default 16, giving the maximum cycles allowed after tx_start for tx_busy to rise.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: bit i high means requester i has a byte pending.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*8 bits: requester i byte on bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot, one-cycle accept pulse.
REQ-008 The block SHALL have port tx_start, output, 1 bit: drives the uart_transmitter tx_start.
REQ-009 The block SHALL have port tx_data, output, 8 bits: drives the uart_transmitter tx_data.
REQ-010 The block SHALL have port tx_busy, input, 1 bit: the uart_transmitter busy output.
REQ-011 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current or last granted requester.
REQ-012 The block SHALL have port active, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky error flag.
REQ-014 The block SHALL have port clear_err, input, 1 bit: clears timeout_err.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE, when any req_valid bit is high and tx_busy is low, the block SHALL select a winner at that edge and go to WAIT_BUSY.
REQ-017 Winner selection SHALL be round-robin: the first valid index at or after rr_ptr, searching upward and wrapping NUM_REQ-1 to 0.
REQ-018 On the grant edge the block SHALL register tx_data to the winner's byte and grant_id to the winner index.
REQ-019 On the grant edge the block SHALL also set tx_start and req_ready[winner] high for exactly one cycle, the first WAIT_BUSY cycle.
REQ-020 The transfer SHALL be complete on the cycle req_ready[i] is high; req_valid is ignored outside IDLE, and the requester drops or replaces its byte the following cycle.
REQ-021 tx_data SHALL hold its value until the next grant.
REQ-022 In WAIT_BUSY, tx_busy high SHALL move the FSM to WAIT_DONE and clear the wait counter.
REQ-023 In WAIT_BUSY, tx_busy low SHALL increment a wait counter that starts at 0 on entry.
REQ-024 When the wait counter reaches BUSY_WAIT_MAX, the block SHALL set timeout_err, go to IDLE and advance rr_ptr.
REQ-025 In WAIT_DONE, tx_busy low SHALL move the FSM to IDLE and set rr_ptr to grant_id+1 mod NUM_REQ.
REQ-026 The block SHALL spend at least one cycle in IDLE between grants.
REQ-027 In IDLE with tx_busy high, the block SHALL make no grant and leave rr_ptr unchanged.
REQ-028 If req_valid drops before a grant, that requester SHALL receive no grant.
REQ-029 A single continuously valid requester SHALL win every slot.
REQ-030 clear_err SHALL clear timeout_err; if a new timeout occurs in the same cycle, set SHALL win.
REQ-031 req_ready SHALL never have more than one bit set, and tx_start SHALL never be high for two consecutive cycles.

Reset
REQ-032 While rst is high at a clock edge, the next state SHALL be: FSM IDLE, rr_ptr=0, wait counter=0, tx_start=0, req_ready=0, tx_data=8'h00, grant_id=0, active=0, timeout_err=0.
REQ-033 rst asserted mid-transfer SHALL abort to IDLE with no further tx_start; the transmitter is reset independently.
REQ-034 A pending req_valid SHALL be arbitrated from rr_ptr=0 on the first edge after rst falls.

Verification
REQ-035 Bench case: requester 2 valid with byte 8'h72, others idle, model busy rising 1 cycle after tx_start -> one-cycle tx_start and req_ready=4'b0100 together, tx_data=8'h72, grant_id=2.
REQ-036 Bench case: all four valid continuously with bytes 8'h10..8'h13 -> grants in order 0,1,2,3,0 and tx_data sequence 10,11,12,13,10.
REQ-037 Bench case: tx_busy never rises after tx_start -> timeout_err=1 after 16 WAIT_BUSY cycles, return to IDLE, next grant goes to the next index.
REQ-038 Bench case: tx_busy held high in IDLE with req_valid=4'b0001 -> no tx_start until tx_busy falls, then a grant to 0.
REQ-039 Bench case: rst pulsed during WAIT_DONE -> all outputs at reset values next cycle, and the next grant starts from index 0.
REQ-040 Bench case: clear_err asserted in the same cycle a timeout fires -> timeout_err stays 1; clear_err on a later cycle -> timeout_err=0.
